// File: rtl/frame_sequencer_pkg.sv
// Shared types and constants for the shift-register frame sequencer and its
// serial generator (source selection is reused by the generator's output mux).
package frame_sequencer_pkg;

    localparam int SIZESRDYN_DEFAULT  = 16;
    localparam int SIZESRSTAT_DEFAULT = 88;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    typedef enum logic {
        SRC_DYN  = 1'b0,
        SRC_STAT = 1'b1
    } src_e;

    function automatic int src_len(input src_e src, input int len_dyn, input int len_stat);
        return (src == SRC_DYN) ? len_dyn : len_stat;
    endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Request/select bundle between the frame sequencer and its requesters/generator.
interface frame_sequencer_if;

    logic enable;
    logic req_dyn;
    logic req_stat;
    logic abort;
    logic seldyn;
    logic selstat;
    logic ack_dyn;
    logic ack_stat;
    logic done_dyn;
    logic done_stat;
    logic frame_valid;
    logic busy;

    modport master (
        input  enable, req_dyn, req_stat, abort,
        output seldyn, selstat, ack_dyn, ack_stat, done_dyn, done_stat, frame_valid, busy
    );

    modport slave (
        output enable, req_dyn, req_stat, abort,
        input  seldyn, selstat, ack_dyn, ack_stat, done_dyn, done_stat, frame_valid, busy
    );

endinterface

// File: rtl/frame_sequencer_rr_arbiter2.sv
// Two-input round-robin arbiter; the pointer remembers the last source granted
// and only moves when the caller actually takes the grant.
module rr_arbiter2
    import frame_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant_valid,
    output src_e       grant_src
);

    src_e last_reg;

    always_comb begin
        grant_valid = |req;
        grant_src   = SRC_DYN;
        if (req[SRC_DYN] && req[SRC_STAT]) begin
            grant_src = (last_reg == SRC_DYN) ? SRC_STAT : SRC_DYN;
        end else if (req[SRC_STAT]) begin
            grant_src = SRC_STAT;
        end
    end

    // Reset as "STAT last served" so DYN wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= SRC_STAT;
        end else if (update && grant_valid) begin
            last_reg <= grant_src;
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// Drives one shift select for a full frame length, then an idle gap; arbitrates
// dynamic vs static requesters round-robin. All outputs are registered.
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int SIZESRDYN  = SIZESRDYN_DEFAULT,
    parameter int SIZESRSTAT = SIZESRSTAT_DEFAULT,
    parameter int GAP        = 2,
    parameter int CNTW       = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    frame_sequencer_if.master bus
);

    localparam int GAPW = (GAP > 1) ? $clog2(GAP) : 1;

    logic [1:0]      state_reg, state_next;
    logic [CNTW-1:0] cnt_reg, cnt_next;
    logic [GAPW-1:0] gap_reg, gap_next;
    src_e            src_reg, src_next;

    logic [1:0] req_raw;
    logic [1:0] req_masked;
    logic       grant_valid;
    src_e       grant_src;
    logic       grant_fire;
    logic       frame_end;

    logic [1:0] sel_reg, sel_next;
    logic [1:0] ack_reg, ack_next;
    logic [1:0] done_reg, done_next;
    logic       frame_valid_reg;
    logic       busy_reg, busy_next;

    assign req_raw[SRC_DYN]  = bus.req_dyn;
    assign req_raw[SRC_STAT] = bus.req_stat;

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign req_masked[gi] = bus.enable & req_raw[gi];
    end

    rr_arbiter2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_masked),
        .update      (grant_fire),
        .grant_valid (grant_valid),
        .grant_src   (grant_src)
    );

    assign grant_fire = (state_reg == ST_IDLE) && grant_valid;
    // An abort in the last select cycle still suppresses the completion pulse.
    assign frame_end  = (state_reg == ST_SHIFT) && (cnt_reg == '0) && !bus.abort;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        gap_next   = gap_reg;
        src_next   = src_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_fire) begin
                    state_next = ST_SHIFT;
                    src_next   = grant_src;
                    cnt_next   = CNTW'(src_len(grant_src, SIZESRDYN, SIZESRSTAT) - 1);
                end
            end
            ST_SHIFT: begin
                if (bus.abort || (cnt_reg == '0)) begin
                    state_next = (GAP == 0) ? ST_IDLE : ST_GAP;
                    gap_next   = GAPW'(GAP - 1);
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_next = gap_reg - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign sel_next[gi]  = (state_next == ST_SHIFT) && (src_next == src_e'(1'(gi)));
        assign ack_next[gi]  = grant_fire && (grant_src == src_e'(1'(gi)));
        assign done_next[gi] = frame_end && (src_reg == src_e'(1'(gi)));
    end

    assign busy_next = (state_next != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            gap_reg         <= '0;
            src_reg         <= SRC_DYN;
            sel_reg         <= '0;
            ack_reg         <= '0;
            done_reg        <= '0;
            frame_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            gap_reg         <= gap_next;
            src_reg         <= src_next;
            sel_reg         <= sel_next;
            ack_reg         <= ack_next;
            done_reg        <= done_next;
            frame_valid_reg <= |sel_reg;
            busy_reg        <= busy_next;
        end
    end

    assign bus.seldyn      = sel_reg[SRC_DYN];
    assign bus.selstat     = sel_reg[SRC_STAT];
    assign bus.ack_dyn     = ack_reg[SRC_DYN];
    assign bus.ack_stat    = ack_reg[SRC_STAT];
    assign bus.done_dyn    = done_reg[SRC_DYN];
    assign bus.done_stat   = done_reg[SRC_STAT];
    assign bus.frame_valid = frame_valid_reg;
    assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: a frame-window model (grant edge, select window,
// done edge, busy window) checked every cycle, plus hand-computed literals.
module tb_frame_sequencer;
    import frame_sequencer_pkg::*;

    localparam int LEN_DYN  = 16;
    localparam int LEN_STAT = 88;
    localparam int GAP      = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    frame_sequencer_if bus_if ();

    frame_sequencer #(
        .SIZESRDYN  (LEN_DYN),
        .SIZESRSTAT (LEN_STAT),
        .GAP        (GAP),
        .CNTW       (7)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: edges counted from reset release; one record for the latest frame.
    int ecnt, m_idle_from, m_grant, m_sel_end, m_done, m_busy_end, m_last, m_src;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecnt = 0; m_idle_from = 1; m_grant = -100; m_sel_end = -100;
            m_done = -100; m_busy_end = -100; m_last = 1; m_src = 0;
        end else begin
            ecnt = ecnt + 1;
            if (bus_if.abort && (ecnt - 1 >= m_grant) && (ecnt - 1 <= m_sel_end)) begin
                m_sel_end   = ecnt - 1;
                m_done      = -100;
                m_busy_end  = ecnt + GAP - 1;
                m_idle_from = ecnt + GAP + 1;
            end else if (ecnt >= m_idle_from && bus_if.enable && (bus_if.req_dyn || bus_if.req_stat)) begin
                int len;
                m_src       = (bus_if.req_dyn && bus_if.req_stat) ? (1 - m_last) : (bus_if.req_stat ? 1 : 0);
                m_last      = m_src;
                len         = (m_src == 0) ? LEN_DYN : LEN_STAT;
                m_grant     = ecnt;
                m_sel_end   = ecnt + len - 1;
                m_done      = ecnt + len;
                m_busy_end  = ecnt + len + GAP - 1;
                m_idle_from = ecnt + len + GAP + 1;
            end
        end
    end

    // Observation statistics for literal checks
    int n_sel_dyn, n_sel_stat, n_fv, n_done_dyn, n_done_stat, n_ack, n_busy;
    int last_ack_ecnt, last_done_ecnt, busy_fall_ecnt;
    int grants[$];
    int ack_edges[$];
    logic prev_busy;
    logic drop_on_ack;

    task automatic clear_stats();
        n_sel_dyn = 0; n_sel_stat = 0; n_fv = 0; n_done_dyn = 0; n_done_stat = 0;
        n_ack = 0; n_busy = 0; last_ack_ecnt = -1; last_done_ecnt = -1; busy_fall_ecnt = -1;
        grants.delete(); ack_edges.delete(); prev_busy = 1'b0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic compare_cycle();
        int x;
        logic e_sel, e_fv, e_busy;
        logic [7:0] a, e;
        x      = ecnt;
        e_sel  = (x >= m_grant) && (x <= m_sel_end);
        e_fv   = (x - 1 >= m_grant) && (x - 1 <= m_sel_end);
        e_busy = (x >= m_grant) && (x <= m_busy_end);
        e = {e_sel && m_src == 0, e_sel && m_src == 1,
             x == m_grant && m_src == 0, x == m_grant && m_src == 1,
             x == m_done && m_src == 0, x == m_done && m_src == 1, e_fv, e_busy};
        a = {bus_if.seldyn, bus_if.selstat, bus_if.ack_dyn, bus_if.ack_stat,
             bus_if.done_dyn, bus_if.done_stat, bus_if.frame_valid, bus_if.busy};
        tests_run++;
        if (a !== e) begin
            tests_failed++;
            $display("FAIL outputs edge=%0d got(sd,ss,ad,as,dd,ds,fv,bz)=%b expected=%b", x, a, e);
        end
        tests_run++;
        if (bus_if.seldyn && bus_if.selstat) begin
            tests_failed++;
            $display("FAIL sel_exclusive edge=%0d got=both_high expected=at_most_one", x);
        end
        n_sel_dyn  += int'(bus_if.seldyn);
        n_sel_stat += int'(bus_if.selstat);
        n_fv       += int'(bus_if.frame_valid);
        n_busy     += int'(bus_if.busy);
        if (bus_if.ack_dyn || bus_if.ack_stat) begin
            n_ack++;
            grants.push_back(bus_if.ack_stat ? 1 : 0);
            ack_edges.push_back(x);
            last_ack_ecnt = x;
            $display("[TB] edge %0d grant %s", x, bus_if.ack_stat ? "STAT" : "DYN");
        end
        if (bus_if.done_dyn || bus_if.done_stat) begin
            n_done_dyn  += int'(bus_if.done_dyn);
            n_done_stat += int'(bus_if.done_stat);
            last_done_ecnt = x;
            $display("[TB] edge %0d done %s", x, bus_if.done_stat ? "STAT" : "DYN");
        end
        if (prev_busy && !bus_if.busy) busy_fall_ecnt = x;
        prev_busy = bus_if.busy;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            compare_cycle();
            if (drop_on_ack) begin
                if (bus_if.ack_dyn)  bus_if.req_dyn  = 1'b0;
                if (bus_if.ack_stat) bus_if.req_stat = 1'b0;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus_if.enable = 1'b0; bus_if.req_dyn = 1'b0; bus_if.req_stat = 1'b0; bus_if.abort = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clear_stats();
        compare_cycle();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        compare_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.enable = 1'b0; bus_if.req_dyn = 1'b0; bus_if.req_stat = 1'b0; bus_if.abort = 1'b0;
        drop_on_ack = 1'b1;
        clear_stats();

        // Single dynamic frame
        apply_reset();
        bus_if.enable = 1'b1; bus_if.req_dyn = 1'b1; drop_on_ack = 1'b1;
        tick(25);
        check("t1_ack_edge", ack_edges.size() > 0 ? ack_edges[0] : -1, 1);
        check("t1_seldyn_cycles", n_sel_dyn, 16);
        check("t1_fv_cycles", n_fv, 16);
        check("t1_done_edge", last_done_ecnt, 17);
        check("t1_done_count", n_done_dyn, 1);
        check("t1_busy_fall_edge", busy_fall_ecnt, 19);

        // Simultaneous requests: DYN first, then STAT after the gap
        apply_reset();
        bus_if.enable = 1'b1; bus_if.req_dyn = 1'b1; bus_if.req_stat = 1'b1;
        tick(115);
        check("t2_grant_count", grants.size(), 2);
        check("t2_first_src", grants.size() > 0 ? grants[0] : -1, 0);
        check("t2_second_src", grants.size() > 1 ? grants[1] : -1, 1);
        check("t2_stat_ack_edge", last_ack_ecnt, 20);
        check("t2_seldyn_cycles", n_sel_dyn, 16);
        check("t2_selstat_cycles", n_sel_stat, 88);
        check("t2_done_stat_count", n_done_stat, 1);

        // Continuous contention for four frames
        apply_reset();
        bus_if.enable = 1'b1; bus_if.req_dyn = 1'b1; bus_if.req_stat = 1'b1; drop_on_ack = 1'b0;
        for (int i = 0; i < 300 && grants.size() < 4; i++) tick(1);
        bus_if.req_dyn = 1'b0; bus_if.req_stat = 1'b0; drop_on_ack = 1'b1;
        check("t3_grant_count", grants.size(), 4);
        check("t3_order0", grants.size() > 0 ? grants[0] : -1, 0);
        check("t3_order1", grants.size() > 1 ? grants[1] : -1, 1);
        check("t3_order2", grants.size() > 2 ? grants[2] : -1, 0);
        check("t3_order3", grants.size() > 3 ? grants[3] : -1, 1);
        check("t3_ack_edge2", ack_edges.size() > 2 ? ack_edges[2] : -1, 111);
        check("t3_ack_edge3", ack_edges.size() > 3 ? ack_edges[3] : -1, 130);
        tick(100);

        // Abort in the 5th static select cycle
        apply_reset();
        bus_if.enable = 1'b1; bus_if.req_stat = 1'b1;
        tick(5);
        bus_if.abort = 1'b1; bus_if.req_dyn = 1'b1; bus_if.req_stat = 1'b1;
        tick(1);
        bus_if.abort = 1'b0;
        check("t4_selstat_cycles", n_sel_stat, 5);
        check("t4_no_done_stat", n_done_stat, 0);
        tick(19);
        bus_if.abort = 1'b1;
        tick(1);
        bus_if.abort = 1'b0;
        check("t4_tie_src", grants.size() > 1 ? grants[1] : -1, 0);
        check("t4_tie_ack_edge", ack_edges.size() > 1 ? ack_edges[1] : -1, 9);
        check("t4_done_dyn_after_gap_abort", n_done_dyn, 1);
        tick(110);

        // Asynchronous reset mid-frame
        apply_reset();
        bus_if.enable = 1'b1; bus_if.req_dyn = 1'b1;
        tick(10);
        check("t5_seldyn_before_reset", int'(bus_if.seldyn), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_seldyn_async", int'(bus_if.seldyn), 0);
        check("t5_fv_async", int'(bus_if.frame_valid), 0);
        check("t5_busy_async", int'(bus_if.busy), 0);
        bus_if.req_dyn = 1'b1; bus_if.req_stat = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        compare_cycle();
        tick(1);
        check("t5_first_tie_src", grants.size() > 0 ? grants[0] : -1, 0);
        check("t5_first_ack_edge", last_ack_ecnt, 1);
        tick(120);

        // ENABLE gating of grants only
        apply_reset();
        bus_if.enable = 1'b0; bus_if.req_stat = 1'b1;
        tick(20);
        check("t6_no_ack_disabled", n_ack, 0);
        check("t6_no_busy_disabled", n_busy, 0);
        bus_if.enable = 1'b1;
        tick(1);
        check("t6_ack_edge", last_ack_ecnt, 21);
        check("t6_ack_src", grants.size() > 0 ? grants[0] : -1, 1);
        tick(10);
        bus_if.enable = 1'b0;
        tick(100);
        check("t6_selstat_cycles", n_sel_stat, 88);
        check("t6_done_stat_count", n_done_stat, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
